// File: rtl/network_sink_if.sv
// Handshake bundle between the network core (net_*) and the host-link transport (snk_*).
// The sink block uses the slave view; whoever drives the network and the link uses the master view.
interface network_sink_if #(
  parameter int NUM_OUT   = 8,
  parameter int SNK_WIDTH = 2 + $clog2(NUM_OUT + 1)
);
  logic                 net_valid;
  logic                 net_ready;
  logic [NUM_OUT-1:0]   net_out;
  logic                 snk_valid;
  logic                 snk_ready;
  logic [SNK_WIDTH-1:0] snk;

  modport master (
    output net_valid, net_out, snk_ready,
    input  net_ready, snk_valid, snk
  );

  modport slave (
    input  net_valid, net_out, snk_ready,
    output net_ready, snk_valid, snk
  );
endinterface

// File: rtl/network_sink.sv
// Serializes one captured network output vector into SPK packets (ascending index)
// followed by a single CYC packet carrying the number of spikes.
module network_sink #(
  parameter  int NUM_OUT   = 8,
  parameter  int OPC_WIDTH = 2,
  localparam int PLD_WIDTH = $clog2(NUM_OUT + 1),
  localparam int SNK_WIDTH = OPC_WIDTH + PLD_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  network_sink_if.slave   bus
);

  localparam logic [OPC_WIDTH-1:0] OPC_SPK = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OPC_CYC = OPC_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_OUT-1:0]   pending_q, pending_d;
  logic [PLD_WIDTH-1:0] count_q, count_d;
  logic [SNK_WIDTH-1:0] snk_p0, snk_d;
  logic                 vld_p0, vld_d;
  logic                 net_ready;

  // Priority encoder: lowest set index wins.
  function automatic logic [PLD_WIDTH-1:0] lowest_idx(input logic [NUM_OUT-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = PLD_WIDTH'(i);
    end
  endfunction

  assign net_ready     = (state_q == IDLE) && !rst;
  assign bus.net_ready = net_ready;
  assign bus.snk       = snk_p0;
  assign bus.snk_valid = vld_p0;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.net_valid && net_ready) begin
          pending_d = bus.net_out;
          count_d   = '0;
          state_d   = (bus.net_out != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (bus.snk_ready) begin
          // Dropping the lowest set bit retires exactly the index just sent.
          pending_d = pending_q & (pending_q - NUM_OUT'(1));
          count_d   = count_q + PLD_WIDTH'(1);
          if (pending_d == '0) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.snk_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Packet is built from the next state so it appears the cycle after each transition.
    snk_d = '0;
    vld_d = 1'b0;
    unique case (state_d)
      SCAN: begin
        snk_d = {OPC_SPK, lowest_idx(pending_d)};
        vld_d = 1'b1;
      end
      DONE: begin
        snk_d = {OPC_CYC, count_d};
        vld_d = 1'b1;
      end
      default: begin
        snk_d = '0;
        vld_d = 1'b0;
      end
    endcase
  end

  // Stage p0: registered packet output and scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      snk_p0    <= '0;
      vld_p0    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      snk_p0    <= snk_d;
      vld_p0    <= vld_d;
    end
  end

endmodule

// File: tb/tb_network_sink.sv
// Scoreboard bench for network_sink: stimulus pushes expected packets, a negedge monitor pops and compares.
module tb_network_sink;
  localparam int N  = 8;
  localparam int PW = 4;
  localparam int SW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  network_sink_if #(.NUM_OUT(N)) bus ();
  network_sink #(.NUM_OUT(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  network_sink_if #(.NUM_OUT(1)) bus1 ();
  network_sink #(.NUM_OUT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int tests = 0;
  int fails = 0;
  logic [SW-1:0] expq[$];

  bit   rand_ready = 1'b0;
  logic ready_rnd  = 1'b1;
  logic ready_dir  = 1'b1;
  assign bus.snk_ready = rand_ready ? ready_rnd : ready_dir;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one SPK per set bit in ascending order, then CYC with the popcount.
  task automatic push_expected(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        expq.push_back({2'd1, PW'(i)});
        c++;
      end
    end
    expq.push_back({2'd2, PW'(c)});
  endtask

  task automatic send(input logic [N-1:0] v);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    push_expected(v);
    bus.net_valid = 1'b1;
    bus.net_out   = v;
    repeat (200) if (!got) begin
      @(negedge clk);
      got = bus.net_ready;
    end
    if (!got) check(1'b0, "capture_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    bus.net_valid = 1'b0;
    bus.net_out   = N'($urandom);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    repeat (300) if (!done) begin
      @(negedge clk);
      done = (expq.size() == 0) && bus.net_ready;
    end
    check(done, "drain_timeout", 32'(expq.size()), 32'(0));
  endtask

  always @(posedge clk) begin
    #1 ready_rnd = ($urandom_range(0, 3) != 0);
  end

  // Monitor: content, hold-under-backpressure and busy/ready consistency.
  logic          prev_stall = 1'b0;
  logic [SW-1:0] prev_snk   = '0;
  logic [SW-1:0] exp_pkt;
  always @(negedge clk) begin
    if (rst) begin
      check(bus.net_ready == 1'b0, "ready_in_reset", 32'(bus.net_ready), 32'(0));
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check(bus.snk_valid && (bus.snk == prev_snk), "hold", 32'(bus.snk), 32'(prev_snk));
      check(bus.net_ready == !bus.snk_valid, "ready_vs_busy", 32'(bus.net_ready), 32'(!bus.snk_valid));
      if (bus.snk_valid && bus.snk_ready) begin
        if (expq.size() == 0) begin
          check(1'b0, "unexpected_packet", 32'(bus.snk), 32'(0));
        end else begin
          exp_pkt = expq.pop_front();
          check(bus.snk == exp_pkt, "packet", 32'(bus.snk), 32'(exp_pkt));
        end
      end
      prev_stall = bus.snk_valid && !bus.snk_ready;
      prev_snk   = bus.snk;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] v;
    bus.net_valid  = 1'b0;
    bus.net_out    = '0;
    bus1.net_valid = 1'b0;
    bus1.net_out   = '0;
    bus1.snk_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(bus.snk_valid == 1'b0, "reset_valid", 32'(bus.snk_valid), 32'(0));
    check(bus.snk == '0, "reset_snk", 32'(bus.snk), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(bus.net_ready == 1'b1, "ready_after_reset", 32'(bus.net_ready), 32'(1));

    // Four back-to-back packets, then ready again.
    ready_dir = 1'b1;
    send(8'b1001_0010);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check(bus.snk_valid == 1'b1, "burst_valid", 32'(bus.snk_valid), 32'(1));
    end
    @(negedge clk);
    check(bus.net_ready == 1'b1, "burst_ready_after", 32'(bus.net_ready), 32'(1));

    // All-zero capture: single CYC 0 right after capture.
    send('0);
    @(negedge clk);
    check(bus.snk_valid && (bus.snk == {2'd2, 4'd0}), "zero_cyc", 32'(bus.snk), 32'({2'd2, 4'd0}));
    @(negedge clk);
    check(bus.net_ready && !bus.snk_valid, "zero_single", 32'(bus.snk_valid), 32'(0));

    // Full vector: maximum count in the payload.
    send(8'hFF);
    wait_idle();

    // Backpressure while SPK 4 is presented, with upstream noise.
    send(8'b1001_0010);
    @(posedge clk);
    #1;
    ready_dir     = 1'b0;
    bus.net_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check(bus.snk_valid && (bus.snk == {2'd1, 4'd4}), "bp_spk4", 32'(bus.snk), 32'({2'd1, 4'd4}));
      check(bus.net_ready == 1'b0, "bp_busy", 32'(bus.net_ready), 32'(0));
      @(posedge clk);
      #1 bus.net_out = N'($urandom);
    end
    bus.net_valid = 1'b0;
    ready_dir     = 1'b1;
    wait_idle();

    // Reset in the middle of a scan, just after SPK 1 is accepted.
    send(8'b1001_0010);
    @(posedge clk);
    #1;
    rst = 1'b1;
    expq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(bus.snk_valid == 1'b0, "mid_reset_valid", 32'(bus.snk_valid), 32'(0));
    check(bus.net_ready == 1'b1, "mid_reset_ready", 32'(bus.net_ready), 32'(1));
    send(8'h01);
    wait_idle();

    // Randomized traffic with random downstream stalls.
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0:       v = '0;
        1:       v = '1;
        default: v = N'($urandom);
      endcase
      send(v);
    end
    wait_idle();
    rand_ready = 1'b0;

    // Single-output build.
    @(posedge clk);
    #1;
    bus1.net_out   = 1'b1;
    bus1.net_valid = 1'b1;
    @(posedge clk);
    #1 bus1.net_valid = 1'b0;
    @(negedge clk);
    check(bus1.snk_valid && (bus1.snk == 3'b010), "n1_spk0", 32'(bus1.snk), 32'(3'b010));
    @(negedge clk);
    check(bus1.snk_valid && (bus1.snk == 3'b101), "n1_cyc1", 32'(bus1.snk), 32'(3'b101));
    @(negedge clk);
    check(bus1.net_ready && !bus1.snk_valid, "n1_idle", 32'(bus1.net_ready), 32'(1));

    check(expq.size() == 0, "queue_drained", 32'(expq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
